// File: rtl/hash_arbiter_pkg.sv
// Shared definitions for the hash arbiter slice: bus widths, boolean
// constants and the arbiter FSM state type.
package hash_arbiter_pkg;

  localparam int QUAD_BUS = 64;
  localparam int DATA_BUS = 32;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  localparam logic [DATA_BUS-1:0] ZERO_WORD = '0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } hash_arb_state_t;

endpackage

// File: rtl/hash_arbiter_rr_pick.sv
// Combinational round-robin picker: returns the first asserted request
// searching upward from last+1, wrapping modulo NUM_REQ.
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    last,
  output logic [ID_W-1:0]    gnt_id,
  output logic               any
);

  int              cand;
  logic [ID_W-1:0] idx;

  // Walk the requesters in rotated order and keep the first hit.
  always_comb begin
    gnt_id = '0;
    any    = 1'b0;
    cand   = 0;
    idx    = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = int'(last) + i;
      if (cand >= NUM_REQ) begin
        cand = cand - NUM_REQ;
      end
      idx = ID_W'(cand);
      if (!any && req[idx]) begin
        gnt_id = idx;
        any    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/hash_arbiter.sv
// Round-robin arbiter sharing one hash unit between NUM_REQ requesters.
// Accepts one key at a time, starts the hash unit, waits for completion
// (or a watchdog timeout) and returns a one-cycle one-hot response pulse.
module hash_arbiter
  import hash_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ),
  parameter int TIMEOUT = 15
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_REQ-1:0]                req_valid_i,
  input  logic [NUM_REQ-1:0][QUAD_BUS-1:0]  req_key_i,
  output logic [NUM_REQ-1:0]                req_ready_o,
  output logic [NUM_REQ-1:0]                resp_valid_o,
  output logic [DATA_BUS-1:0]               resp_val_o,
  output logic                              resp_err_o,
  output logic                              hash_start_o,
  output logic [QUAD_BUS-1:0]               hash_key_o,
  input  logic                              hash_ready_i,
  input  logic [DATA_BUS-1:0]               hash_val_i,
  output logic                              busy_o
);

  localparam int WD_W = $clog2(TIMEOUT + 1);

  hash_arb_state_t  state;
  logic [ID_W-1:0]  last_grant;
  logic [ID_W-1:0]  grant_id;
  logic [WD_W-1:0]  wd;
  logic [ID_W-1:0]  pick_id;
  logic             pick_any;

  function automatic logic [NUM_REQ-1:0] onehot(input logic [ID_W-1:0] id);
    logic [NUM_REQ-1:0] v;
    v     = '0;
    v[id] = TRUE;
    return v;
  endfunction

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr_pick (
    .req    (req_valid_i),
    .last   (last_grant),
    .gnt_id (pick_id),
    .any    (pick_any)
  );

  assign busy_o = (state != IDLE);

  // Arbiter FSM: grant, issue one start pulse, then wait for completion or timeout.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      last_grant   <= ID_W'(NUM_REQ - 1);
      grant_id     <= '0;
      wd           <= '0;
      req_ready_o  <= '0;
      resp_valid_o <= '0;
      resp_val_o   <= ZERO_WORD;
      resp_err_o   <= FALSE;
      hash_start_o <= FALSE;
      hash_key_o   <= '0;
    end else begin
      // Pulsed outputs drop back to zero unless re-asserted below.
      req_ready_o  <= '0;
      resp_valid_o <= '0;
      resp_err_o   <= FALSE;
      hash_start_o <= FALSE;
      case (state)
        IDLE: begin
          if (pick_any) begin
            grant_id     <= pick_id;
            last_grant   <= pick_id;
            hash_key_o   <= req_key_i[pick_id];
            req_ready_o  <= onehot(pick_id);
            hash_start_o <= TRUE;
            state        <= ISSUE;
          end
        end
        ISSUE: begin
          wd    <= '0;
          state <= WAIT;
        end
        WAIT: begin
          wd <= wd + 1'b1;
          // wd==0 is the first WAIT cycle; hash_ready_i is not trusted there.
          if ((wd != '0) && hash_ready_i) begin
            resp_valid_o <= onehot(grant_id);
            resp_val_o   <= hash_val_i;
            resp_err_o   <= FALSE;
            state        <= IDLE;
          end else if (wd == WD_W'(TIMEOUT - 1)) begin
            resp_valid_o <= onehot(grant_id);
            resp_val_o   <= ZERO_WORD;
            resp_err_o   <= TRUE;
            state        <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hash_arbiter.sv
// Directed bench for hash_arbiter with a small stub hash unit that returns a
// programmed value a programmable number of cycles after start.
module tb_hash_arbiter;

  logic              clk;
  logic              rst;
  logic [3:0]        req_valid;
  logic [3:0][63:0]  req_key;
  logic [3:0]        req_ready;
  logic [3:0]        resp_valid;
  logic [31:0]       resp_val;
  logic              resp_err;
  logic              hash_start;
  logic [63:0]       hash_key;
  logic              hash_ready;
  logic [31:0]       hash_val;
  logic              busy;

  int nchecks;
  int nerrs;

  // Stub hash unit controls
  int          stub_delay;
  logic [31:0] stub_val;
  int          stub_cnt;

  hash_arbiter #(
    .NUM_REQ (4),
    .ID_W    (2),
    .TIMEOUT (15)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid_i  (req_valid),
    .req_key_i    (req_key),
    .req_ready_o  (req_ready),
    .resp_valid_o (resp_valid),
    .resp_val_o   (resp_val),
    .resp_err_o   (resp_err),
    .hash_start_o (hash_start),
    .hash_key_o   (hash_key),
    .hash_ready_i (hash_ready),
    .hash_val_i   (hash_val),
    .busy_o       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stub: clears ready on start; ready rises stub_delay edges later (0 = never).
  always @(posedge clk) begin
    if (rst) begin
      stub_cnt   <= 0;
      hash_ready <= 1'b0;
      hash_val   <= '0;
    end else if (hash_start) begin
      stub_cnt   <= stub_delay;
      hash_ready <= 1'b0;
    end else if (stub_cnt != 0) begin
      stub_cnt <= stub_cnt - 1;
      if (stub_cnt == 1) begin
        hash_ready <= 1'b1;
        hash_val   <= stub_val;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    rst        = 1'b1;
    req_valid  = '0;
    req_key    = '0;
    stub_delay = 2;
    stub_val   = '0;
    tick(2);
    nchecks++;
    if ({req_ready, resp_valid, resp_err, hash_start, busy} !== 11'b0) begin
      nerrs++;
      $display("FAIL reset_ctrl got %b want 0", {req_ready, resp_valid, resp_err, hash_start, busy});
    end
    nchecks++;
    if ({resp_val, hash_key} !== 96'h0) begin
      nerrs++;
      $display("FAIL reset_data got %h want 0", {resp_val, hash_key});
    end
    rst = 1'b0;
    tick(1);
    nchecks++;
    if (busy !== 1'b0) begin
      nerrs++;
      $display("FAIL reset_idle busy got %b want 0", busy);
    end
  endtask

  task automatic test_single;
    stub_delay = 2;
    stub_val   = 32'h24;
    req_key[0] = 64'h0102030405060708;
    req_valid  = 4'b0001;
    tick(1);
    nchecks++;
    if (req_ready !== 4'b0001 || hash_start !== 1'b1) begin
      nerrs++;
      $display("FAIL single_accept ready=%b start=%b want 0001/1", req_ready, hash_start);
    end
    nchecks++;
    if (hash_key !== 64'h0102030405060708) begin
      nerrs++;
      $display("FAIL single_key got %h want 0102030405060708", hash_key);
    end
    req_valid = '0;
    tick(1);
    nchecks++;
    if (req_ready !== 4'b0000 || hash_start !== 1'b0 || busy !== 1'b1) begin
      nerrs++;
      $display("FAIL single_pulse ready=%b start=%b busy=%b want 0000/0/1", req_ready, hash_start, busy);
    end
    tick(2);
    nchecks++;
    if (resp_valid !== 4'b0000) begin
      nerrs++;
      $display("FAIL single_early resp_valid got %b want 0000", resp_valid);
    end
    tick(1);
    nchecks++;
    if (resp_valid !== 4'b0001 || resp_val !== 32'h24 || resp_err !== 1'b0 || busy !== 1'b0) begin
      nerrs++;
      $display("FAIL single_resp valid=%b val=%h err=%b busy=%b want 0001/24/0/0",
               resp_valid, resp_val, resp_err, busy);
    end
    tick(1);
    nchecks++;
    if (resp_valid !== 4'b0000 || resp_val !== 32'h24) begin
      nerrs++;
      $display("FAIL single_hold valid=%b val=%h want 0000/24", resp_valid, resp_val);
    end
  endtask

  task automatic test_round_robin;
    logic [3:0] exp_oh;
    rst = 1'b1;
    tick(1);
    rst        = 1'b0;
    stub_delay = 2;
    req_key[0] = 64'hA000_0000_0000_0000;
    req_key[1] = 64'hA111_1111_1111_1111;
    req_key[2] = 64'hA222_2222_2222_2222;
    req_key[3] = 64'hA333_3333_3333_3333;
    req_valid  = 4'b1111;
    tick(1);
    for (int k = 0; k < 5; k++) begin
      exp_oh   = 4'b0001 << (k % 4);
      stub_val = 32'h100 + k;
      nchecks++;
      if (req_ready !== exp_oh || hash_key !== req_key[k % 4]) begin
        nerrs++;
        $display("FAIL rr_grant%0d ready=%b key=%h want %b/%h", k, req_ready, hash_key, exp_oh, req_key[k % 4]);
      end
      tick(4);
      nchecks++;
      if (resp_valid !== exp_oh || resp_val !== 32'h100 + k || resp_err !== 1'b0) begin
        nerrs++;
        $display("FAIL rr_resp%0d valid=%b val=%h err=%b want %b/%h/0",
                 k, resp_valid, resp_val, resp_err, exp_oh, 32'h100 + k);
      end
      if (k == 4) req_valid = '0;
      tick(1);
    end
    nchecks++;
    if (req_ready !== 4'b0000 || busy !== 1'b0) begin
      nerrs++;
      $display("FAIL rr_stop ready=%b busy=%b want 0000/0", req_ready, busy);
    end
  endtask

  task automatic test_back_to_back;
    stub_delay = 2;
    stub_val   = 32'h08;
    req_key[2] = 64'hFFFF_FFFF_FFFF_FFFF;
    req_valid  = 4'b0100;
    tick(1);
    nchecks++;
    if (req_ready !== 4'b0100 || hash_key !== 64'hFFFF_FFFF_FFFF_FFFF) begin
      nerrs++;
      $display("FAIL b2b_grant1 ready=%b key=%h want 0100/ffffffffffffffff", req_ready, hash_key);
    end
    req_key[2] = 64'h0;
    tick(4);
    nchecks++;
    if (resp_valid !== 4'b0100 || resp_val !== 32'h08) begin
      nerrs++;
      $display("FAIL b2b_resp1 valid=%b val=%h want 0100/08", resp_valid, resp_val);
    end
    tick(1);
    stub_val = 32'h00;
    nchecks++;
    if (req_ready !== 4'b0100 || hash_key !== 64'h0) begin
      nerrs++;
      $display("FAIL b2b_grant2 ready=%b key=%h want 0100/0", req_ready, hash_key);
    end
    req_valid = '0;
    tick(3);
    nchecks++;
    if (resp_valid !== 4'b0000) begin
      nerrs++;
      $display("FAIL b2b_early resp_valid got %b want 0000", resp_valid);
    end
    tick(1);
    nchecks++;
    if (resp_valid !== 4'b0100 || resp_val !== 32'h00 || resp_err !== 1'b0) begin
      nerrs++;
      $display("FAIL b2b_resp2 valid=%b val=%h err=%b want 0100/0/0", resp_valid, resp_val, resp_err);
    end
  endtask

  task automatic test_timeout;
    stub_delay = 0;
    req_key[1] = 64'h1234_5678_9ABC_DEF0;
    req_valid  = 4'b0010;
    tick(1);
    nchecks++;
    if (req_ready !== 4'b0010) begin
      nerrs++;
      $display("FAIL to_grant ready=%b want 0010", req_ready);
    end
    req_valid = '0;
    tick(15);
    nchecks++;
    if (resp_valid !== 4'b0000 || busy !== 1'b1) begin
      nerrs++;
      $display("FAIL to_early valid=%b busy=%b want 0000/1", resp_valid, busy);
    end
    tick(1);
    nchecks++;
    if (resp_valid !== 4'b0010 || resp_err !== 1'b1 || resp_val !== 32'h0 || busy !== 1'b0) begin
      nerrs++;
      $display("FAIL to_resp valid=%b err=%b val=%h busy=%b want 0010/1/0/0",
               resp_valid, resp_err, resp_val, busy);
    end
    tick(1);
    nchecks++;
    if (resp_valid !== 4'b0000 || resp_err !== 1'b0) begin
      nerrs++;
      $display("FAIL to_clear valid=%b err=%b want 0000/0", resp_valid, resp_err);
    end
    stub_delay = 2;
    stub_val   = 32'h5A;
    req_key[0] = 64'h55;
    req_valid  = 4'b0001;
    tick(1);
    nchecks++;
    if (req_ready !== 4'b0001) begin
      nerrs++;
      $display("FAIL to_next_grant ready=%b want 0001", req_ready);
    end
    req_valid = '0;
    tick(4);
    nchecks++;
    if (resp_valid !== 4'b0001 || resp_val !== 32'h5A || resp_err !== 1'b0) begin
      nerrs++;
      $display("FAIL to_next_resp valid=%b val=%h err=%b want 0001/5a/0", resp_valid, resp_val, resp_err);
    end
    tick(1);
  endtask

  task automatic test_reset_mid_job;
    stub_delay = 2;
    stub_val   = 32'h77;
    req_key[2] = 64'hDEAD;
    req_valid  = 4'b0100;
    tick(1);
    req_valid = '0;
    tick(1);
    rst = 1'b1;
    tick(1);
    nchecks++;
    if ({req_ready, resp_valid, resp_err, hash_start, busy} !== 11'b0 ||
        {resp_val, hash_key} !== 96'h0) begin
      nerrs++;
      $display("FAIL midrst_outputs ctrl=%b data=%h want 0/0",
               {req_ready, resp_valid, resp_err, hash_start, busy}, {resp_val, hash_key});
    end
    rst = 1'b0;
    tick(2);
    nchecks++;
    if (resp_valid !== 4'b0000 || busy !== 1'b0) begin
      nerrs++;
      $display("FAIL midrst_noresp valid=%b busy=%b want 0000/0", resp_valid, busy);
    end
    stub_val   = 32'h30;
    req_key[0] = 64'h0F0F;
    req_key[3] = 64'hF0F0;
    req_valid  = 4'b1001;
    tick(1);
    nchecks++;
    if (req_ready !== 4'b0001 || hash_key !== 64'h0F0F) begin
      nerrs++;
      $display("FAIL midrst_prio ready=%b key=%h want 0001/0f0f", req_ready, hash_key);
    end
    req_valid = 4'b1000;
    tick(4);
    nchecks++;
    if (resp_valid !== 4'b0001 || resp_val !== 32'h30) begin
      nerrs++;
      $display("FAIL midrst_resp0 valid=%b val=%h want 0001/30", resp_valid, resp_val);
    end
    stub_val = 32'h33;
    tick(1);
    nchecks++;
    if (req_ready !== 4'b1000 || hash_key !== 64'hF0F0) begin
      nerrs++;
      $display("FAIL midrst_grant3 ready=%b key=%h want 1000/f0f0", req_ready, hash_key);
    end
    req_valid = '0;
    tick(4);
    nchecks++;
    if (resp_valid !== 4'b1000 || resp_val !== 32'h33) begin
      nerrs++;
      $display("FAIL midrst_resp3 valid=%b val=%h want 1000/33", resp_valid, resp_val);
    end
    tick(1);
  endtask

  task automatic test_same_cycle;
    stub_delay = 14;
    stub_val   = 32'h00C0FFEE;
    req_key[1] = 64'hBEEF;
    req_valid  = 4'b0010;
    tick(1);
    nchecks++;
    if (req_ready !== 4'b0010) begin
      nerrs++;
      $display("FAIL same_grant ready=%b want 0010", req_ready);
    end
    req_valid = '0;
    tick(15);
    nchecks++;
    if (resp_valid !== 4'b0000 || busy !== 1'b1) begin
      nerrs++;
      $display("FAIL same_early valid=%b busy=%b want 0000/1", resp_valid, busy);
    end
    tick(1);
    nchecks++;
    if (resp_valid !== 4'b0010 || resp_err !== 1'b0 || resp_val !== 32'h00C0FFEE) begin
      nerrs++;
      $display("FAIL same_resp valid=%b err=%b val=%h want 0010/0/00c0ffee", resp_valid, resp_err, resp_val);
    end
    tick(1);
  endtask

  initial begin
    nchecks = 0;
    nerrs   = 0;
    test_reset();
    test_single();
    test_round_robin();
    test_back_to_back();
    test_timeout();
    test_reset_mid_job();
    test_same_cycle();
    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrs);
    $finish;
  end

endmodule
